// File: rtl/video_timing_gen.sv
// Horizontal + vertical video timing generator: syncs, active flag, pixel-divided
// frame-buffer addresses and line/frame strobes, all registered from next-count decode.
module video_timing_gen #(
    parameter int unsigned H_TOTAL   = 1600,
    parameter int unsigned H_SYNC    = 192,
    parameter int unsigned H_BACK    = 96,
    parameter int unsigned H_ACTIVE  = 200,
    parameter int unsigned PIX_DIV   = 6,
    parameter int unsigned V_TOTAL   = 525,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned HADDR_W   = 8,
    parameter int unsigned VADDR_W   = 9,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [HADDR_W-1:0] haddr,
    output logic [VADDR_W-1:0] vaddr,
    output logic               line_start,
    output logic               frame_start
);

    localparam int unsigned H_START = H_SYNC + H_BACK;
    localparam int unsigned H_END   = H_START + H_ACTIVE * PIX_DIV;
    localparam int unsigned V_START = V_SYNC + V_BACK;
    localparam int unsigned V_END   = V_START + V_ACTIVE;
    localparam int unsigned HCNT_W  = $clog2(H_TOTAL + 1);
    localparam int unsigned VCNT_W  = $clog2(V_TOTAL + 1);
    localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [HCNT_W-1:0] H_LAST    = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_SYNC_C  = HCNT_W'(H_SYNC);
    localparam logic [HCNT_W-1:0] H_START_C = HCNT_W'(H_START);
    localparam logic [HCNT_W-1:0] H_END_C   = HCNT_W'(H_END);
    localparam logic [VCNT_W-1:0] V_LAST    = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_SYNC_C  = VCNT_W'(V_SYNC);
    localparam logic [VCNT_W-1:0] V_START_C = VCNT_W'(V_START);
    localparam logic [VCNT_W-1:0] V_END_C   = VCNT_W'(V_END);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PIX_DIV - 1);

    // Reject configurations whose windows overrun the frame or whose addresses overflow.
    if ((H_TOTAL < 1) || (V_TOTAL < 1) || (PIX_DIV < 1) ||
        (H_END > H_TOTAL) || (V_END > V_TOTAL) ||
        (64'(H_ACTIVE) > (64'd1 << HADDR_W)) ||
        (64'(V_ACTIVE) > (64'd1 << VADDR_W))) begin : g_cfg_check
        $error("video_timing_gen: illegal timing configuration");
    end

    logic [HCNT_W-1:0]  hcnt_q, hcnt_d, hcnt_nxt;
    logic [VCNT_W-1:0]  vcnt_q, vcnt_d, vcnt_nxt;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [HADDR_W-1:0] haddr_q, haddr_d;
    logic [VADDR_W-1:0] vaddr_q, vaddr_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               active_q, active_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic               h_act_nxt, v_act_nxt;

    // Decode outputs from the counter values the next edge will load, so they line up with them.
    always_comb begin
        hcnt_nxt = (hcnt_q == H_LAST) ? '0 : hcnt_q + HCNT_W'(1);
        vcnt_nxt = vcnt_q;
        if (hcnt_q == H_LAST) begin
            vcnt_nxt = (vcnt_q == V_LAST) ? '0 : vcnt_q + VCNT_W'(1);
        end
        h_act_nxt = (hcnt_nxt >= H_START_C) && (hcnt_nxt < H_END_C);
        v_act_nxt = (vcnt_nxt >= V_START_C) && (vcnt_nxt < V_END_C);

        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        div_d         = div_q;
        haddr_d       = haddr_q;
        vaddr_d       = vaddr_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (en) begin
            hcnt_d        = hcnt_nxt;
            vcnt_d        = vcnt_nxt;
            hsync_d       = (hcnt_nxt < H_SYNC_C) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = (vcnt_nxt < V_SYNC_C) ? VSYNC_POL : ~VSYNC_POL;
            active_d      = h_act_nxt && v_act_nxt;
            vaddr_d       = v_act_nxt ? VADDR_W'(vcnt_nxt - V_START_C) : '0;
            line_start_d  = (hcnt_nxt == '0);
            frame_start_d = (hcnt_nxt == '0) && (vcnt_nxt == '0);
            // Pixel divider restarts at the first active clock of every line.
            if (!h_act_nxt || (hcnt_nxt == H_START_C)) begin
                div_d   = '0;
                haddr_d = '0;
            end else if (div_q == DIV_LAST) begin
                div_d   = '0;
                haddr_d = haddr_q + HADDR_W'(1);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            div_q         <= '0;
            haddr_q       <= '0;
            vaddr_q       <= '0;
            hsync_q       <= HSYNC_POL;
            vsync_q       <= VSYNC_POL;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            div_q         <= div_d;
            haddr_q       <= haddr_d;
            vaddr_q       <= vaddr_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign haddr       = haddr_q;
    assign vaddr       = vaddr_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
